ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single data RAM port between two requesters: the CPU memory stage (load/store) and the VGA framebuffer scanout reader.
- Sits between the memory-stage/VGA logic and the RAM array. Arbitrates per cycle, issues at most one access per cycle, and tracks in-flight reads with a tag pipeline so each read response returns to its owner.
- Runs on the single pipeline clock.

Parameters:
- AW, 14, word address width.
- DW, 32, data width; must be a multiple of 8.
- MEM_LAT, 1, RAM read latency in cycles from mem_en to valid mem_rdata; legal range 1..4.
- STARVE_MAX, 8, consecutive CPU losses to VGA-urgent before the CPU is forced to win one slot.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- cpu_req_valid  in  1  CPU request present
- cpu_req_ready  out  1  CPU request accepted this cycle
- cpu_req_we  in  1  1 = store, 0 = load
- cpu_req_addr  in  AW  word address
- cpu_req_wdata  in  DW  store data
- cpu_req_wstrb  in  DW/8  byte enables for stores
- cpu_rsp_valid  out  1  one-cycle pulse: load data valid or store complete
- cpu_rsp_rdata  out  DW  load data; 0 for store acks
- vga_req_valid  in  1  VGA read request present
- vga_req_ready  out  1  VGA request accepted this cycle
- vga_req_addr  in  AW  word address
- vga_urgent  in  1  VGA line buffer below low watermark
- vga_rsp_valid  out  1  one-cycle pulse: VGA read data valid
- vga_rsp_rdata  out  DW  VGA read data
- mem_en  out  1  RAM access strobe
- mem_wstrb  out  DW/8  byte write enables; all zero for reads
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, MEM_LAT cycles after mem_en
- starve_events  out  16  saturating count of forced-CPU grants (debug)

Behaviour:
- Reset: asynchronous assert when rst=0, released synchronously to clk.
  - All outputs are 0; tag pipeline is cleared; rr_last = VGA (so CPU wins the first tie); starve_cnt = 0; starve_events = 0.
- Grant decision is combinational within the cycle; at most one grant per cycle.
  - If exactly one valid, that requester wins.
  - If both are valid:
    - starve_cnt == STARVE_MAX: CPU wins.
    - Otherwise, vga_urgent = 1: VGA wins.
    - Otherwise: round-robin; the requester not equal to rr_last wins.
- Handshake:
  - req_ready = 1 only for the winner.
  - A transfer happens on valid & ready at the clk edge.
  - ready may depend combinationally on valid. Requesters must hold valid and payload stable until accepted.
- Memory drive:
  - On a grant, mem_en = 1 in the same cycle with the winner's address.
  - mem_wstrb = cpu_req_wstrb for CPU stores, 0 otherwise.
  - mem_wdata = cpu_req_wdata for CPU stores, don't-care otherwise.
  - With no grant, mem_en = 0 and mem_wstrb = 0.
- Tag pipeline: MEM_LAT stages of {valid, owner, is_write}, shifted every cycle and loaded at stage 0 on a grant.
  - When the last stage is valid, pulse the owner's rsp_valid for one cycle.
  - rdata = mem_rdata for reads, 0 for CPU store acks. VGA requests are never writes.
  - Latency: request accepted at edge N, response visible in the cycle after edge N+MEM_LAT−1, i.e. exactly MEM_LAT cycles after acceptance.
  - Responses are never back-pressured. A new grant and a response may occur in the same cycle (full throughput of 1 access/cycle).
- rr_last updates to the winner on every grant; it holds when there is no grant.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, when cpu_req_valid = 1 and VGA is granted.
  - Resets to 0 on any CPU grant, or when cpu_req_valid = 0.
  - A forced CPU grant (both valid, starve_cnt == STARVE_MAX, vga_urgent = 1) increments starve_events, saturating at 0xFFFF.
- Reset mid-operation: in-flight tags are discarded and no responses are emitted for them. Requesters must reissue.
- Address and data widths pass through unchanged; there is no address decoding or range check.

Decomposition:
- Shared package: owner_e enum (OWN_CPU, OWN_VGA) and the mem_tag_t struct {valid, owner, is_write}.
- One natural sub-module: ram_tag_pipe, a parameterised MEM_LAT-deep shift register of mem_tag_t with async active-low clear.
- Arbitration and starvation logic stay in ram_arbiter.

Test Plan:
- CPU only; load at addr 0x10 (RAM holds 0xDEADBEEF), MEM_LAT=1 -> cpu_req_ready=1 same cycle; cpu_rsp_valid pulses 1 cycle later with 0xDEADBEEF; vga_rsp_valid stays 0.
- CPU store addr 0x20, wdata 0x12345678, wstrb 4'b0011 -> mem_wstrb=0011 in the grant cycle; cpu_rsp_valid with rdata 0 after MEM_LAT; a later load returns 0x????5678 with the upper bytes unchanged.
- Both valid continuously, vga_urgent=0 -> grants alternate CPU, VGA, CPU, VGA starting with CPU; 1 access/cycle; responses are routed to the correct owner.
- Both valid, vga_urgent=1 held, STARVE_MAX=8 -> 8 VGA grants, then 1 CPU grant, then VGA again; starve_events increments to 1.
- MEM_LAT=3, back-to-back VGA reads of addresses 0..5 -> vga_rsp_valid asserted 6 consecutive cycles starting 3 cycles after the first accept, data in address order.
- Assert rst=0 asynchronously with 2 reads in flight -> all outputs 0 immediately; after release no stale rsp_valid; the first tie is won by CPU.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared types for the data-RAM arbiter.
//   owner_e   - which requester an access belongs to
//   mem_tag_t - per-access bookkeeping carried alongside an in-flight RAM access
package ram_arbiter_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_VGA = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   is_write;
    } mem_tag_t;

    localparam mem_tag_t TAG_IDLE = '{valid: 1'b0, owner: OWN_CPU, is_write: 1'b0};

endpackage

// File: rtl/ram_tag_pipe.sv
// ram_tag_pipe: DEPTH-deep shift register of access tags. It mirrors the RAM
// read latency so each response can be steered back to its owner.
//   clk   - pipeline clock
//   rst   - asynchronous active-low clear (all stages become TAG_IDLE)
//   tag_i - tag of the access issued this cycle (valid=0 when no access)
//   tag_o - tag whose RAM data is on mem_rdata this cycle
module ram_tag_pipe
    import ram_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  mem_tag_t tag_i,
    output mem_tag_t tag_o
);

    mem_tag_t tag_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= TAG_IDLE;
            end
        end else begin
            tag_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tag_o = tag_q[DEPTH-1];

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one data-RAM port between the CPU memory stage and the
// VGA scanout reader. One access per cycle, combinational grant, responses
// routed back to their owner through ram_tag_pipe.
//   clk, rst                 - pipeline clock, async active-low reset
//   cpu_req_* / cpu_rsp_*    - CPU load/store request and response
//   vga_req_* / vga_rsp_*    - VGA read request and response, vga_urgent priority hint
//   mem_*                    - RAM port (mem_rdata arrives MEM_LAT cycles after mem_en)
//   starve_events            - saturating count of forced CPU grants
// DW must be a multiple of 8; MEM_LAT must be 1..4.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int AW         = 14,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_req_valid,
    output logic            cpu_req_ready,
    input  logic            cpu_req_we,
    input  logic [AW-1:0]   cpu_req_addr,
    input  logic [DW-1:0]   cpu_req_wdata,
    input  logic [DW/8-1:0] cpu_req_wstrb,
    output logic            cpu_rsp_valid,
    output logic [DW-1:0]   cpu_rsp_rdata,
    input  logic            vga_req_valid,
    output logic            vga_req_ready,
    input  logic [AW-1:0]   vga_req_addr,
    input  logic            vga_urgent,
    output logic            vga_rsp_valid,
    output logic [DW-1:0]   vga_rsp_rdata,
    output logic            mem_en,
    output logic [DW/8-1:0] mem_wstrb,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    output logic [15:0]     starve_events
);

    localparam int SCW = $clog2(STARVE_MAX + 1);

    owner_e          rr_last_q, rr_last_d;
    logic [SCW-1:0]  starve_cnt_q, starve_cnt_d;
    logic [15:0]     starve_events_q, starve_events_d;

    logic     cpu_v, vga_v, both_v, starved;
    logic     grant_cpu, grant_vga, grant, cpu_store, forced;
    mem_tag_t tag_new, tag_last;

    // Requests are masked while reset is held so every output reads 0 then,
    // even though ready is combinational from valid.
    assign cpu_v   = cpu_req_valid & rst;
    assign vga_v   = vga_req_valid & rst;
    assign both_v  = cpu_v & vga_v;
    assign starved = (starve_cnt_q == SCW'(STARVE_MAX));

    always_comb begin
        grant_cpu = 1'b0;
        grant_vga = 1'b0;
        if (both_v) begin
            if (starved)                  grant_cpu = 1'b1;
            else if (vga_urgent)          grant_vga = 1'b1;
            else if (rr_last_q == OWN_VGA) grant_cpu = 1'b1;
            else                          grant_vga = 1'b1;
        end else begin
            grant_cpu = cpu_v;
            grant_vga = vga_v;
        end
    end

    assign grant     = grant_cpu | grant_vga;
    assign cpu_store = grant_cpu & cpu_req_we;
    // Only counts as a starvation event when urgency would otherwise have won.
    assign forced    = grant_cpu & both_v & starved & vga_urgent;

    assign cpu_req_ready = grant_cpu;
    assign vga_req_ready = grant_vga;

    assign mem_en    = grant;
    assign mem_addr  = grant_cpu ? cpu_req_addr : (grant_vga ? vga_req_addr : '0);
    assign mem_wstrb = cpu_store ? cpu_req_wstrb : '0;
    assign mem_wdata = cpu_store ? cpu_req_wdata : '0;

    assign tag_new = '{valid:    grant,
                       owner:    grant_cpu ? OWN_CPU : OWN_VGA,
                       is_write: cpu_store};

    ram_tag_pipe #(.DEPTH(MEM_LAT)) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .tag_i (tag_new),
        .tag_o (tag_last)
    );

    assign cpu_rsp_valid = tag_last.valid & (tag_last.owner == OWN_CPU);
    assign vga_rsp_valid = tag_last.valid & (tag_last.owner == OWN_VGA);
    assign cpu_rsp_rdata = (cpu_rsp_valid & ~tag_last.is_write) ? mem_rdata : '0;
    assign vga_rsp_rdata = vga_rsp_valid ? mem_rdata : '0;

    always_comb begin
        rr_last_d       = rr_last_q;
        starve_cnt_d    = starve_cnt_q;
        starve_events_d = starve_events_q;
        if (grant) begin
            rr_last_d = grant_cpu ? OWN_CPU : OWN_VGA;
        end
        if (!cpu_req_valid || grant_cpu) begin
            starve_cnt_d = '0;
        end else if (grant_vga && !starved) begin
            starve_cnt_d = starve_cnt_q + SCW'(1);
        end
        if (forced && (starve_events_q != 16'hFFFF)) begin
            starve_events_d = starve_events_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last_q       <= OWN_VGA;
            starve_cnt_q    <= '0;
            starve_events_q <= '0;
        end else begin
            rr_last_q       <= rr_last_d;
            starve_cnt_q    <= starve_cnt_d;
            starve_events_q <= starve_events_d;
        end
    end

    assign starve_events = starve_events_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: two arbiters (MEM_LAT=1 and MEM_LAT=3) share one stimulus
// stream and a behavioural RAM; a transaction-level model predicts grants,
// memory drive, starvation counts and the response stream for both.
module tb_ram_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int STARVE_MAX = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          cpu_req_valid, cpu_req_we, vga_req_valid, vga_urgent;
    logic [AW-1:0] cpu_req_addr, vga_req_addr;
    logic [DW-1:0] cpu_req_wdata;
    logic [SW-1:0] cpu_req_wstrb;

    logic          cpu_req_ready_1, vga_req_ready_1, cpu_rsp_valid_1, vga_rsp_valid_1, mem_en_1;
    logic [DW-1:0] cpu_rsp_rdata_1, vga_rsp_rdata_1, mem_wdata_1, mem_rdata_1;
    logic [SW-1:0] mem_wstrb_1;
    logic [AW-1:0] mem_addr_1;
    logic [15:0]   starve_events_1;

    logic          cpu_req_ready_3, vga_req_ready_3, cpu_rsp_valid_3, vga_rsp_valid_3, mem_en_3;
    logic [DW-1:0] cpu_rsp_rdata_3, vga_rsp_rdata_3, mem_wdata_3, mem_rdata_3;
    logic [SW-1:0] mem_wstrb_3;
    logic [AW-1:0] mem_addr_3;
    logic [15:0]   starve_events_3;

    ram_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .STARVE_MAX(STARVE_MAX)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready_1), .cpu_req_we(cpu_req_we),
        .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata), .cpu_req_wstrb(cpu_req_wstrb),
        .cpu_rsp_valid(cpu_rsp_valid_1), .cpu_rsp_rdata(cpu_rsp_rdata_1),
        .vga_req_valid(vga_req_valid), .vga_req_ready(vga_req_ready_1), .vga_req_addr(vga_req_addr),
        .vga_urgent(vga_urgent), .vga_rsp_valid(vga_rsp_valid_1), .vga_rsp_rdata(vga_rsp_rdata_1),
        .mem_en(mem_en_1), .mem_wstrb(mem_wstrb_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
        .mem_rdata(mem_rdata_1), .starve_events(starve_events_1)
    );

    ram_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3), .STARVE_MAX(STARVE_MAX)) u_dut_l3 (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready_3), .cpu_req_we(cpu_req_we),
        .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata), .cpu_req_wstrb(cpu_req_wstrb),
        .cpu_rsp_valid(cpu_rsp_valid_3), .cpu_rsp_rdata(cpu_rsp_rdata_3),
        .vga_req_valid(vga_req_valid), .vga_req_ready(vga_req_ready_3), .vga_req_addr(vga_req_addr),
        .vga_urgent(vga_urgent), .vga_rsp_valid(vga_rsp_valid_3), .vga_rsp_rdata(vga_rsp_rdata_3),
        .mem_en(mem_en_3), .mem_wstrb(mem_wstrb_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
        .mem_rdata(mem_rdata_3), .starve_events(starve_events_3)
    );

    // Behavioural RAM: driven by the MEM_LAT=1 instance's writes (both instances
    // issue the same accesses), read data delayed per instance latency.
    logic [DW-1:0] ram [256];
    logic [DW-1:0] rd1_q;
    logic [DW-1:0] rd3_q [3];
    logic [DW-1:0] ram_word;

    always @(posedge clk) begin
        if (mem_en_1) begin
            rd1_q <= ram[mem_addr_1[7:0]];
            ram_word = ram[mem_addr_1[7:0]];
            for (int b = 0; b < SW; b++) begin
                if (mem_wstrb_1[b]) ram_word[8*b +: 8] = mem_wdata_1[8*b +: 8];
            end
            ram[mem_addr_1[7:0]] = ram_word;
        end
        rd3_q[0] <= mem_en_3 ? ram[mem_addr_3[7:0]] : '0;
        rd3_q[1] <= rd3_q[0];
        rd3_q[2] <= rd3_q[1];
    end

    assign mem_rdata_1 = rd1_q;
    assign mem_rdata_3 = rd3_q[2];

    // Reference model
    typedef struct {
        int            due;
        bit            is_cpu;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          q1[$];
    exp_t          q3[$];
    logic [DW-1:0] model_mem [256];
    bit            m_last_cpu;
    int            m_starve, m_events, cyc;
    bit            e_cpu, e_vga;
    int            cpu_prob, vga_prob, urg_prob;
    int            checks = 0;
    int            errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q1.delete();
        q3.delete();
        m_last_cpu = 1'b0;
        m_starve   = 0;
        m_events   = 0;
    endtask

    task automatic check_idle(input string nm, input logic cr, input logic vr, input logic en,
                              input logic [SW-1:0] ws, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input logic cv, input logic [DW-1:0] cd, input logic vv,
                              input logic [DW-1:0] vd, input logic [15:0] se);
        check_val({nm, " rst cpu_req_ready"}, 32'(cr), 32'd0);
        check_val({nm, " rst vga_req_ready"}, 32'(vr), 32'd0);
        check_val({nm, " rst mem_en"},        32'(en), 32'd0);
        check_val({nm, " rst mem_wstrb"},     32'(ws), 32'd0);
        check_val({nm, " rst mem_addr"},      32'(a),  32'd0);
        check_val({nm, " rst mem_wdata"},     wd,      32'd0);
        check_val({nm, " rst cpu_rsp_valid"}, 32'(cv), 32'd0);
        check_val({nm, " rst cpu_rsp_rdata"}, cd,      32'd0);
        check_val({nm, " rst vga_rsp_valid"}, 32'(vv), 32'd0);
        check_val({nm, " rst vga_rsp_rdata"}, vd,      32'd0);
        check_val({nm, " rst starve_events"}, 32'(se), 32'd0);
    endtask

    task automatic check_port(input string nm, input logic cr, input logic vr, input logic en,
                              input logic [SW-1:0] ws, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, input logic [15:0] se);
        bit st;
        st = e_cpu && cpu_req_we;
        check_val({nm, " cpu_req_ready"}, 32'(cr), 32'(e_cpu));
        check_val({nm, " vga_req_ready"}, 32'(vr), 32'(e_vga));
        check_val({nm, " mem_en"},        32'(en), 32'(e_cpu || e_vga));
        check_val({nm, " mem_wstrb"},     32'(ws), st ? 32'(cpu_req_wstrb) : 32'd0);
        if (e_cpu || e_vga)
            check_val({nm, " mem_addr"}, 32'(a), e_cpu ? 32'(cpu_req_addr) : 32'(vga_req_addr));
        if (st)
            check_val({nm, " mem_wdata"}, wd, cpu_req_wdata);
        check_val({nm, " starve_events"}, 32'(se), 32'(m_events));
    endtask

    task automatic check_rsp(input string nm, input bit exp_v, input exp_t e,
                             input logic cv, input logic [DW-1:0] cd,
                             input logic vv, input logic [DW-1:0] vd);
        bit exp_cv, exp_vv;
        exp_cv = exp_v && e.is_cpu;
        exp_vv = exp_v && !e.is_cpu;
        check_val({nm, " cpu_rsp_valid"}, 32'(cv), 32'(exp_cv));
        check_val({nm, " vga_rsp_valid"}, 32'(vv), 32'(exp_vv));
        if (exp_cv) check_val({nm, " cpu_rsp_rdata"}, cd, e.data);
        if (exp_vv) check_val({nm, " vga_rsp_rdata"}, vd, e.data);
    endtask

    // Called mid-cycle with inputs stable: predict this cycle and compare.
    task automatic check_cycle();
        exp_t e;
        bit   v;
        e_cpu = 1'b0;
        e_vga = 1'b0;
        if (cpu_req_valid && vga_req_valid) begin
            if (m_starve == STARVE_MAX) e_cpu = 1'b1;
            else if (vga_urgent)        e_vga = 1'b1;
            else if (m_last_cpu)        e_vga = 1'b1;
            else                        e_cpu = 1'b1;
        end else begin
            e_cpu = cpu_req_valid;
            e_vga = vga_req_valid;
        end
        check_port("l1", cpu_req_ready_1, vga_req_ready_1, mem_en_1, mem_wstrb_1, mem_addr_1,
                   mem_wdata_1, starve_events_1);
        check_port("l3", cpu_req_ready_3, vga_req_ready_3, mem_en_3, mem_wstrb_3, mem_addr_3,
                   mem_wdata_3, starve_events_3);

        e = '{due: 0, is_cpu: 1'b0, data: '0};
        v = (q1.size() > 0) && (q1[0].due == cyc);
        if (v) e = q1.pop_front();
        check_rsp("l1", v, e, cpu_rsp_valid_1, cpu_rsp_rdata_1, vga_rsp_valid_1, vga_rsp_rdata_1);
        e = '{due: 0, is_cpu: 1'b0, data: '0};
        v = (q3.size() > 0) && (q3[0].due == cyc);
        if (v) e = q3.pop_front();
        check_rsp("l3", v, e, cpu_rsp_valid_3, cpu_rsp_rdata_3, vga_rsp_valid_3, vga_rsp_rdata_3);
    endtask

    // Called at the clock edge: apply the predicted transfer to the model.
    task automatic commit();
        exp_t e;
        int   idx;
        bit   st, forced;
        forced = cpu_req_valid && vga_req_valid && (m_starve == STARVE_MAX) && vga_urgent;
        if (e_cpu || e_vga) begin
            idx      = e_cpu ? int'(cpu_req_addr[7:0]) : int'(vga_req_addr[7:0]);
            st       = e_cpu && cpu_req_we;
            e.is_cpu = e_cpu;
            e.data   = st ? '0 : model_mem[idx];
            e.due    = cyc + 1;
            q1.push_back(e);
            e.due    = cyc + 3;
            q3.push_back(e);
            if (st) begin
                for (int b = 0; b < SW; b++)
                    if (cpu_req_wstrb[b]) model_mem[idx][8*b +: 8] = cpu_req_wdata[8*b +: 8];
            end
            m_last_cpu = e_cpu;
        end
        if (forced && m_events < 16'hFFFF) m_events++;
        if (!cpu_req_valid || e_cpu)                m_starve = 0;
        else if (e_vga && m_starve < STARVE_MAX)    m_starve++;
        cyc++;
    endtask

    task automatic new_cpu();
        cpu_req_valid = 1'b1;
        cpu_req_we    = ($urandom_range(0, 99) < 40);
        cpu_req_addr  = AW'($urandom_range(0, 255));
        cpu_req_wdata = $urandom;
        cpu_req_wstrb = SW'($urandom_range(1, 15));
    endtask

    task automatic new_vga();
        vga_req_valid = 1'b1;
        vga_req_addr  = AW'($urandom_range(0, 255));
    endtask

    task automatic refill();
        if (e_cpu) cpu_req_valid = 1'b0;
        if (e_vga) vga_req_valid = 1'b0;
        if (!cpu_req_valid && $urandom_range(0, 99) < cpu_prob) new_cpu();
        if (!vga_req_valid && $urandom_range(0, 99) < vga_prob) new_vga();
        vga_urgent = ($urandom_range(0, 99) < urg_prob);
    endtask

    task automatic cycle();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        commit();
        #1;
        refill();
    endtask

    task automatic set_mode(input int cp, input int vp, input int up);
        cpu_prob = cp;
        vga_prob = vp;
        urg_prob = up;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]       = 32'h1000_0000 + i * 32'h0001_0101;
            model_mem[i] = 32'h1000_0000 + i * 32'h0001_0101;
        end
        ram[16'h10]       = 32'hDEAD_BEEF;
        model_mem[16'h10] = 32'hDEAD_BEEF;
        rd1_q = '0;
        for (int i = 0; i < 3; i++) rd3_q[i] = '0;

        // Reset with both requesters asserting: nothing may be granted.
        rst = 1'b0;
        cyc = 0;
        set_mode(100, 100, 0);
        new_cpu();
        new_vga();
        vga_urgent = 1'b1;
        model_reset();
        #3;
        check_idle("l1", cpu_req_ready_1, vga_req_ready_1, mem_en_1, mem_wstrb_1, mem_addr_1, mem_wdata_1,
                   cpu_rsp_valid_1, cpu_rsp_rdata_1, vga_rsp_valid_1, vga_rsp_rdata_1, starve_events_1);
        @(posedge clk);
        #1;
        vga_urgent = 1'b0;
        rst = 1'b1;

        // Continuous contention, no urgency: strict alternation starting with CPU.
        repeat (8) cycle();
        set_mode(0, 0, 0);
        repeat (6) cycle();

        // CPU load of the preloaded word.
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = AW'(16'h10);
        cpu_req_wstrb = '1;   cpu_req_wdata = '0;
        repeat (5) cycle();

        // Partial store then read-back.
        cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cpu_req_addr = AW'(16'h20);
        cpu_req_wdata = 32'h1234_5678; cpu_req_wstrb = 4'b0011;
        repeat (4) cycle();
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = AW'(16'h20);
        repeat (5) cycle();

        // Urgent VGA against a busy CPU: eight VGA wins then one forced CPU grant.
        set_mode(100, 100, 100);
        new_cpu();
        new_vga();
        vga_urgent = 1'b1;
        repeat (12) cycle();
        check_val("starve_events after starvation l1", 32'(starve_events_1), 32'd1);
        check_val("starve_events after starvation l3", 32'(starve_events_3), 32'd1);
        set_mode(0, 0, 0);
        repeat (6) cycle();

        // Back-to-back VGA burst over addresses 0..5.
        for (int i = 0; i < 6; i++) begin
            vga_req_valid = 1'b1;
            vga_req_addr  = AW'(i);
            cycle();
        end
        repeat (5) cycle();

        // Randomised traffic, moderate then heavy urgency.
        set_mode(60, 60, 30);
        repeat (1500) cycle();
        set_mode(90, 90, 90);
        repeat (400) cycle();

        // Reset with reads in flight.
        set_mode(0, 100, 0);
        cpu_req_valid = 1'b0;
        repeat (3) cycle();
        #1;
        rst = 1'b0;
        #1;
        model_reset();
        check_idle("l1", cpu_req_ready_1, vga_req_ready_1, mem_en_1, mem_wstrb_1, mem_addr_1, mem_wdata_1,
                   cpu_rsp_valid_1, cpu_rsp_rdata_1, vga_rsp_valid_1, vga_rsp_rdata_1, starve_events_1);
        check_idle("l3", cpu_req_ready_3, vga_req_ready_3, mem_en_3, mem_wstrb_3, mem_addr_3, mem_wdata_3,
                   cpu_rsp_valid_3, cpu_rsp_rdata_3, vga_rsp_valid_3, vga_rsp_rdata_3, starve_events_3);
        @(posedge clk);
        #1;
        check_idle("l3", cpu_req_ready_3, vga_req_ready_3, mem_en_3, mem_wstrb_3, mem_addr_3, mem_wdata_3,
                   cpu_rsp_valid_3, cpu_rsp_rdata_3, vga_rsp_valid_3, vga_rsp_rdata_3, starve_events_3);
        new_cpu();
        cpu_req_we = 1'b0;
        new_vga();
        vga_urgent = 1'b0;
        rst = 1'b1;
        set_mode(50, 50, 20);
        repeat (40) cycle();
        set_mode(0, 0, 0);
        repeat (6) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
